// File: rtl/osc_sweep_calibrator_if.sv
// rtl/osc_sweep_calibrator_if.sv - control/status bundle between register block and sweep calibrator (SWEEP_ABORT_EN adds ABORT)
interface osc_sweep_calibrator_if #(
    parameter int PERIOD_INT_PART  = 10,
    parameter int PERIOD_FRAC_PART = 20,
    parameter int STEP_COUNT_BITS  = 12,
    parameter int DWELL_BITS       = 16,
    parameter int MEAS_WIDTH       = 16
);
    localparam int PW = PERIOD_INT_PART + PERIOD_FRAC_PART;

    logic                       CE;
    logic                       START;
    logic [PW-1:0]              START_PERIOD;
    logic [PW-1:0]              STEP;
    logic [STEP_COUNT_BITS-1:0] STEP_COUNT;
    logic [DWELL_BITS-1:0]      DWELL;
    logic [MEAS_WIDTH-1:0]      MEAS_IN;
    logic                       MEAS_VALID;
`ifdef SWEEP_ABORT_EN
    logic                       ABORT;
`endif
    logic                       OVERRIDE_EN;
    logic [PW-1:0]              OVERRIDE_PERIOD;
    logic                       BUSY;
    logic                       DONE;
    logic [PW-1:0]              BEST_PERIOD;
    logic [MEAS_WIDTH-1:0]      BEST_MEAS;

    modport master (
`ifdef SWEEP_ABORT_EN
        output ABORT,
`endif
        output CE, START, START_PERIOD, STEP, STEP_COUNT, DWELL, MEAS_IN, MEAS_VALID,
        input  OVERRIDE_EN, OVERRIDE_PERIOD, BUSY, DONE, BEST_PERIOD, BEST_MEAS
    );

    modport slave (
`ifdef SWEEP_ABORT_EN
        input  ABORT,
`endif
        input  CE, START, START_PERIOD, STEP, STEP_COUNT, DWELL, MEAS_IN, MEAS_VALID,
        output OVERRIDE_EN, OVERRIDE_PERIOD, BUSY, DONE, BEST_PERIOD, BEST_MEAS
    );
endinterface

// File: rtl/osc_sweep_calibrator.sv
// rtl/osc_sweep_calibrator.sv - NCO period sweep sequencer with peak measurement capture (optional SWEEP_ABORT_EN)
module osc_sweep_calibrator #(
    parameter int PERIOD_INT_PART  = 10,
    parameter int PERIOD_FRAC_PART = 20,
    parameter int STEP_COUNT_BITS  = 12,
    parameter int DWELL_BITS       = 16,
    parameter int MEAS_WIDTH       = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    osc_sweep_calibrator_if.slave bus
);
    localparam int PW = PERIOD_INT_PART + PERIOD_FRAC_PART;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [PW-1:0]              r_step;
    logic [STEP_COUNT_BITS-1:0] r_step_count;
    logic [STEP_COUNT_BITS-1:0] r_index;
    logic [DWELL_BITS-1:0]      r_dwell;
    logic [DWELL_BITS-1:0]      r_dwell_cnt;
    logic [PW-1:0]              r_override_period;
    logic [PW-1:0]              r_best_period;
    logic [MEAS_WIDTH-1:0]      r_best_meas;
    logic                       r_override_en;
    logic                       r_busy;
    logic                       r_done;

    logic [PW:0]                w_sum;
    logic [PW-1:0]              w_next_period;
    logic                       w_abort;

    // Next sweep point; a carry out pins the period at all-ones so it never wraps
    assign w_sum         = {1'b0, r_override_period} + {1'b0, r_step};
    assign w_next_period = w_sum[PW] ? {PW{1'b1}} : w_sum[PW-1:0];

`ifdef SWEEP_ABORT_EN
    assign w_abort = bus.ABORT;
`else
    assign w_abort = 1'b0;
`endif

    // Sweep sequencer: all outputs are registers updated on CE cycles only
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state           <= S_IDLE;
            r_step            <= '0;
            r_step_count      <= '0;
            r_index           <= '0;
            r_dwell           <= '0;
            r_dwell_cnt       <= '0;
            r_override_period <= '0;
            r_best_period     <= '0;
            r_best_meas       <= '0;
            r_override_en     <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
        end else if (bus.CE) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_step            <= bus.STEP;
                        r_step_count      <= bus.STEP_COUNT;
                        r_dwell           <= bus.DWELL;
                        r_dwell_cnt       <= bus.DWELL;
                        r_override_period <= bus.START_PERIOD;
                        r_best_period     <= bus.START_PERIOD;
                        r_best_meas       <= '0;
                        r_index           <= '0;
                        r_override_en     <= 1'b1;
                        r_busy            <= 1'b1;
                        r_state           <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_abort) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (r_dwell_cnt == '0) begin
                        r_state <= S_MEASURE;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (w_abort) begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (bus.MEAS_VALID) begin
                        // Strict compare keeps the earliest period on ties
                        if (bus.MEAS_IN > r_best_meas) begin
                            r_best_meas   <= bus.MEAS_IN;
                            r_best_period <= r_override_period;
                        end
                        if (r_index == r_step_count) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_override_period <= w_next_period;
                            r_index           <= r_index + 1'b1;
                            r_dwell_cnt       <= r_dwell;
                            r_state           <= S_SETTLE;
                        end
                    end
                end
                S_FINISH: begin
                    r_done        <= 1'b0;
                    r_override_en <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.OVERRIDE_EN     = r_override_en;
    assign bus.OVERRIDE_PERIOD = r_override_period;
    assign bus.BUSY            = r_busy;
    assign bus.DONE            = r_done;
    assign bus.BEST_PERIOD     = r_best_period;
    assign bus.BEST_MEAS       = r_best_meas;
endmodule

// File: tb/tb_osc_sweep_calibrator.sv
// tb/tb_osc_sweep_calibrator.sv - self-checking bench for osc_sweep_calibrator
module tb_osc_sweep_calibrator;
    localparam int PW = 30;
    localparam logic [PW-1:0] PMAX = {PW{1'b1}};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    osc_sweep_calibrator_if bus ();

    osc_sweep_calibrator dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    int done_cnt;
    bit ce_rand;
    bit in_sweep;
    logic [15:0] meas_arr [0:15];

    typedef struct {
        logic [PW-1:0] sp;
        logic [PW-1:0] st;
        logic [11:0]   sc;
        logic [15:0]   dw;
        int            w;
        logic [15:0]   m [0:3];
        logic [PW-1:0] bp;
        logic [15:0]   bm;
    } vec_t;

    vec_t tbl [0:4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One CE cycle, optionally preceded by CE-low cycles carrying junk strobes
    task automatic step(input logic start, input logic valid, input logic [15:0] meas);
        if (ce_rand) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                bus.CE         = 1'b0;
                bus.MEAS_VALID = 1'($urandom);
                bus.MEAS_IN    = 16'hFFFF;
                bus.START      = 1'($urandom);
                @(negedge clk);
            end
        end
        bus.CE         = 1'b1;
        bus.MEAS_VALID = valid;
        bus.MEAS_IN    = meas;
        bus.START      = start | (in_sweep & 1'($urandom));
        @(negedge clk);
        if (bus.BUSY) busy_cnt++;
        if (bus.DONE) done_cnt++;
    endtask

    function automatic logic [PW-1:0] model_period(input logic [PW-1:0] sp, input logic [PW-1:0] st, input int i);
        longint unsigned raw;
        raw = longint'(sp) + longint'(i) * longint'(st);
        return (raw > longint'(PMAX)) ? PMAX : raw[PW-1:0];
    endfunction

    task automatic run_sweep(input logic [PW-1:0] sp, input logic [PW-1:0] st,
                             input logic [11:0] sc, input logic [15:0] dw, input int w);
        logic [PW-1:0] best_p;
        logic [15:0]   best_m;
        busy_cnt = 0;
        done_cnt = 0;
        in_sweep = 1'b0;
        bus.START_PERIOD = sp;
        bus.STEP         = st;
        bus.STEP_COUNT   = sc;
        bus.DWELL        = dw;
        step(1'b1, 1'b0, 16'h0);
        in_sweep = 1'b1;
        bus.START_PERIOD = PW'($urandom);
        bus.STEP         = PW'($urandom);
        bus.STEP_COUNT   = 12'($urandom);
        bus.DWELL        = 16'($urandom);
        chk("start_busy", 32'(bus.BUSY), 32'd1);
        chk("start_override_en", 32'(bus.OVERRIDE_EN), 32'd1);
        chk("start_best_meas", 32'(bus.BEST_MEAS), 32'd0);
        chk("start_best_period", 32'(bus.BEST_PERIOD), 32'(sp));
        best_p = sp;
        best_m = 16'h0;
        for (int i = 0; i <= int'(sc); i++) begin
            chk("point_period", 32'(bus.OVERRIDE_PERIOD), 32'(model_period(sp, st, i)));
            for (int k = 0; k <= int'(dw); k++) step(1'b0, 1'($urandom), 16'hFFFF);
            for (int k = 1; k < w; k++) step(1'b0, 1'b0, 16'($urandom));
            step(1'b0, 1'b1, meas_arr[i]);
            if (meas_arr[i] > best_m) begin
                best_m = meas_arr[i];
                best_p = model_period(sp, st, i);
            end
            if (i < int'(sc)) chk("mid_done", 32'(bus.DONE), 32'd0);
            else              chk("end_done", 32'(bus.DONE), 32'd1);
        end
        step(1'b0, 1'b0, 16'h0);
        in_sweep = 1'b0;
        chk("post_done", 32'(bus.DONE), 32'd0);
        chk("post_busy", 32'(bus.BUSY), 32'd0);
        chk("post_override_en", 32'(bus.OVERRIDE_EN), 32'd0);
        chk("best_period", 32'(bus.BEST_PERIOD), 32'(best_p));
        chk("best_meas", 32'(bus.BEST_MEAS), 32'(best_m));
        chk("busy_cycles", 32'(busy_cnt), 32'((int'(sc) + 1) * (int'(dw) + 1 + w) + 1));
        chk("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        bus.CE = 1'b0; bus.START = 1'b0; bus.START_PERIOD = '0; bus.STEP = '0;
        bus.STEP_COUNT = '0; bus.DWELL = '0; bus.MEAS_IN = '0; bus.MEAS_VALID = 1'b0;
`ifdef SWEEP_ABORT_EN
        bus.ABORT = 1'b0;
`endif
        ce_rand = 1'b0;
        in_sweep = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_override_en", 32'(bus.OVERRIDE_EN), 32'd0);
        chk("rst_override_period", 32'(bus.OVERRIDE_PERIOD), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_best_period", 32'(bus.BEST_PERIOD), 32'd0);
        chk("rst_best_meas", 32'(bus.BEST_MEAS), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        tbl[0] = '{sp: 30'h0A000000, st: 30'h00100000, sc: 12'd3, dw: 16'd2, w: 1,
                   m: '{16'd5, 16'd9, 16'd9, 16'd3}, bp: 30'h0A100000, bm: 16'd9};
        tbl[1] = '{sp: 30'h3FFFFFF0, st: 30'h00000010, sc: 12'd2, dw: 16'd1, w: 2,
                   m: '{16'd1, 16'd2, 16'd7, 16'd0}, bp: 30'h3FFFFFFF, bm: 16'd7};
        tbl[2] = '{sp: 30'h00ABCDEF, st: 30'h00001000, sc: 12'd0, dw: 16'd0, w: 1,
                   m: '{16'h1234, 16'd0, 16'd0, 16'd0}, bp: 30'h00ABCDEF, bm: 16'h1234};
        tbl[3] = '{sp: 30'h00000200, st: 30'h00000005, sc: 12'd3, dw: 16'd0, w: 3,
                   m: '{16'd0, 16'd0, 16'd0, 16'd0}, bp: 30'h00000200, bm: 16'd0};
        tbl[4] = '{sp: 30'h00001000, st: 30'h00000100, sc: 12'd3, dw: 16'd1, w: 1,
                   m: '{16'h80, 16'h40, 16'h20, 16'h10}, bp: 30'h00001000, bm: 16'h80};

        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < 4; j++) meas_arr[j] = tbl[t].m[j];
            run_sweep(tbl[t].sp, tbl[t].st, tbl[t].sc, tbl[t].dw, tbl[t].w);
            chk("tbl_best_period", 32'(bus.BEST_PERIOD), 32'(tbl[t].bp));
            chk("tbl_best_meas", 32'(bus.BEST_MEAS), 32'(tbl[t].bm));
        end

        // DONE stretches while CE is low; strobes during CE-low are ignored
        ce_rand = 1'b0;
        bus.START_PERIOD = 30'h100; bus.STEP = 30'h1; bus.STEP_COUNT = 12'd0; bus.DWELL = 16'd0;
        step(1'b1, 1'b0, 16'h0);
        in_sweep = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0042);
        chk("stretch_done_first", 32'(bus.DONE), 32'd1);
        for (int k = 0; k < 3; k++) begin
            bus.CE = 1'b0; bus.MEAS_VALID = 1'b1; bus.MEAS_IN = 16'hFFFF;
            @(negedge clk);
            chk("stretch_done_held", 32'(bus.DONE), 32'd1);
            chk("stretch_busy_held", 32'(bus.BUSY), 32'd1);
        end
        step(1'b0, 1'b0, 16'h0);
        in_sweep = 1'b0;
        chk("stretch_done_clear", 32'(bus.DONE), 32'd0);
        chk("stretch_override_en", 32'(bus.OVERRIDE_EN), 32'd0);
        chk("stretch_best_meas", 32'(bus.BEST_MEAS), 32'h42);

        // Asynchronous reset while waiting in MEASURE of point 2
        bus.START_PERIOD = 30'h1000; bus.STEP = 30'h10; bus.STEP_COUNT = 12'd3; bus.DWELL = 16'd2;
        step(1'b1, 1'b0, 16'h0);
        in_sweep = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0);
            step(1'b0, 1'b1, 16'h0011);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h0);
        chk("pre_reset_period", 32'(bus.OVERRIDE_PERIOD), 32'h1020);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_override_en", 32'(bus.OVERRIDE_EN), 32'd0);
        chk("arst_override_period", 32'(bus.OVERRIDE_PERIOD), 32'd0);
        chk("arst_busy", 32'(bus.BUSY), 32'd0);
        chk("arst_best_meas", 32'(bus.BEST_MEAS), 32'd0);
        chk("arst_best_period", 32'(bus.BEST_PERIOD), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_sweep = 1'b0;
        meas_arr[0] = 16'd3; meas_arr[1] = 16'd8;
        run_sweep(30'h2000, 30'h40, 12'd1, 16'd1, 1);

`ifdef SWEEP_ABORT_EN
        // ABORT beats a simultaneous measurement on point 1
        bus.START_PERIOD = 30'h500; bus.STEP = 30'h20; bus.STEP_COUNT = 12'd3; bus.DWELL = 16'd1;
        step(1'b1, 1'b0, 16'h0);
        in_sweep = 1'b1;
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0030);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 16'h0);
        bus.ABORT = 1'b1;
        step(1'b0, 1'b1, 16'h0099);
        bus.ABORT = 1'b0;
        chk("abort_done", 32'(bus.DONE), 32'd1);
        chk("abort_best_meas", 32'(bus.BEST_MEAS), 32'h30);
        chk("abort_best_period", 32'(bus.BEST_PERIOD), 32'h500);
        step(1'b0, 1'b0, 16'h0);
        in_sweep = 1'b0;
        chk("abort_done_clear", 32'(bus.DONE), 32'd0);
        chk("abort_override_en", 32'(bus.OVERRIDE_EN), 32'd0);
`endif

        // Randomized sweeps with CE gaps and stray strobes
        ce_rand = 1'b1;
        for (int r = 0; r < 20; r++) begin
            logic [PW-1:0] sp;
            logic [PW-1:0] st;
            logic [11:0]   sc;
            logic [15:0]   dw;
            int            w;
            sp = (($urandom % 4) == 0) ? PMAX - PW'($urandom_range(0, 64)) : PW'($urandom);
            st = (($urandom % 2) == 0) ? PW'($urandom_range(0, 255)) : PW'($urandom);
            sc = 12'($urandom_range(0, 7));
            dw = 16'($urandom_range(0, 4));
            w  = $urandom_range(1, 3);
            for (int j = 0; j < 16; j++) meas_arr[j] = 16'($urandom_range(0, 16'hFFFE));
            run_sweep(sp, st, sc, dw, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/osc_sweep_calibrator.md
# osc_sweep_calibrator

Calibration sequencer for the smooth NCO: drives its override period/enable pair through a programmable linear period sweep, holds each point for a settle interval, and captures one external measurement per point (for example, sensor amplitude). It tracks the period that gave the largest measurement and reports it for software or for the auto-tune logic. It sits between the register block and the smooth oscillator's `OVERRIDE_EN` and `OVERRIDE_PERIOD_IN` inputs.

## Interface
- `PERIOD_INT_PART`, 10, integer bits of period (CLK cycles)
- `PERIOD_FRAC_PART`, 20, fractional bits of period
- `STEP_COUNT_BITS`, 12, width of step count
- `DWELL_BITS`, 16, width of settle counter
- `MEAS_WIDTH`, 16, width of measurement

Ports (`PW` = `PERIOD_INT_PART+PERIOD_FRAC_PART`):
- `CLK` in 1: parallel data clock
- `RESET_N` in 1: asynchronous, active-low reset
- `CE` in 1: clock enable; state advances only when 1
- `START` in 1: start sweep; sampled only in IDLE
- `START_PERIOD` in PW: first sweep period
- `STEP` in PW: unsigned period increment per point
- `STEP_COUNT` in STEP_COUNT_BITS: the sweep has STEP_COUNT+1 points
- `DWELL` in DWELL_BITS: settle cycles before each measurement
- `MEAS_IN` in MEAS_WIDTH: measurement value
- `MEAS_VALID` in 1: MEAS_IN valid strobe
- `OVERRIDE_EN` out 1: connects to oscillator OVERRIDE_EN
- `OVERRIDE_PERIOD` out PW: connects to oscillator OVERRIDE_PERIOD_IN
- `BUSY` out 1: sweep in progress
- `DONE` out 1: one-cycle pulse at sweep end
- `BEST_PERIOD` out PW: period of the maximum measurement
- `BEST_MEAS` out MEAS_WIDTH: maximum measurement

## Operation
- **Reset values.** All outputs reset to 0, the FSM goes to IDLE, and all counters are cleared. Reset is asynchronous and can occur in any state, including mid-sweep; `OVERRIDE_EN` drops immediately.
- **IDLE**
  - On `START`&`CE`, the block latches `STEP`, `STEP_COUNT` and `DWELL`.
  - It loads `OVERRIDE_PERIOD`←`START_PERIOD`, `BEST_PERIOD`←`START_PERIOD`, `BEST_MEAS`←0 and index←0.
  - It sets `OVERRIDE_EN`=1 and `BUSY`=1, loads the dwell counter←`DWELL`, and moves to SETTLE.
  - Input changes after the start cycle have no effect until the next start.
- **SETTLE**
  - Each `CE` cycle: if the counter is 0, move to MEASURE; otherwise decrement.
  - Counting starts from the loaded `DWELL` value, so SETTLE lasts `DWELL`+1 `CE` cycles. `DWELL`=0 gives one cycle.
- **MEASURE**
  - The block waits for `MEAS_VALID`&`CE`.
  - If `MEAS_IN` > `BEST_MEAS` (strict compare, so the first maximum wins), it updates `BEST_MEAS`←`MEAS_IN` and `BEST_PERIOD`←`OVERRIDE_PERIOD`.
  - If index == latched `STEP_COUNT`, go to FINISH.
  - Otherwise: `OVERRIDE_PERIOD`←`OVERRIDE_PERIOD`+`STEP`, index++, dwell counter←`DWELL`, go to SETTLE.
  - The period add saturates at all-ones. Once saturated, the remaining points repeat that period.
- **FINISH** (one `CE` cycle):
  - `DONE`=1 for that cycle.
  - `OVERRIDE_EN`←0, `BUSY`←0, then go to IDLE.
  - `BEST_*` hold their values until the next `START`.
- **Ignored inputs.** `MEAS_VALID` is ignored outside MEASURE. `START` is ignored while `BUSY`.
- **CE low.** With `CE`=0, all registers hold, including `DONE` (the pulse stretches until the next `CE` cycle).

## Timing
- **Start latency.** With `START` sampled at edge t, `BUSY`, `OVERRIDE_EN` and `OVERRIDE_PERIOD` are valid after edge t.
- **Measurement effect.** A measurement accepted at edge m updates `BEST_*` and `OVERRIDE_PERIOD` after edge m. The next SETTLE begins at edge m+1.
- **Sweep length.** With `CE`=1 continuously and `MEAS_VALID` arriving w cycles after entering MEASURE (w≥1):
  - each point takes `DWELL`+1+w cycles;
  - total `BUSY` time = (`STEP_COUNT`+1)·(`DWELL`+1+w)+1 cycles.
- **Downstream filter.** The downstream smooth filter lags, so `DWELL` must cover the filter settle time. The block does not enforce this.
- **Registered outputs.** All outputs are registered; there are no combinational paths from input to output.

## Configuration
- **`SWEEP_ABORT_EN` defined**
  - Adds input port `ABORT` (1 bit).
  - `ABORT`&`CE` in SETTLE or MEASURE sends the FSM to FINISH on the next edge: `DONE` pulses and `OVERRIDE_EN` drops.
  - `BEST_*` keep the values from completed points.
  - `ABORT` has priority over a simultaneous `MEAS_VALID` (that measurement is discarded).
- **`SWEEP_ABORT_EN` undefined**
  - The port does not exist. A sweep ends only on completion or reset.

## Test plan
- **Basic sweep.** `START_PERIOD`=0x0A000000, `STEP`=0x00100000, `STEP_COUNT`=3, `DWELL`=2, `MEAS_VALID` 1 cycle after MEASURE entry with `MEAS_IN`=5,9,9,3 → `OVERRIDE_PERIOD` steps 0x0A000000/0A100000/0A200000/0A300000, `BEST_PERIOD`=0x0A100000, `BEST_MEAS`=9, `DONE` after 4·4+1=17 `BUSY` cycles.
- **Zero dwell, single point.** `DWELL`=0, `STEP_COUNT`=0 → one SETTLE cycle, one measurement, `DONE` pulse, `OVERRIDE_EN`=0 afterward.
- **Saturation.** `START_PERIOD`=0x3FFFFFF0, `STEP`=0x10, `STEP_COUNT`=2 → periods 0x3FFFFFF0, 0x3FFFFFFF, 0x3FFFFFFF; no wrap.
- **CE gating and ignored inputs.** `CE` toggled 1/0 and `MEAS_VALID` pulsed during SETTLE → stray strobes ignored, dwell counts only `CE` cycles, `DONE` held high while `CE`=0; `START` while busy has no effect.
- **Async reset mid-sweep.** Assert `RESET_N`=0 in MEASURE of point 2 → all outputs 0 immediately; a fresh `START` runs normally.
- **Abort (`SWEEP_ABORT_EN`).** `ABORT` together with `MEAS_VALID` on point 1 → that measurement is discarded, `BEST_*` reflect point 0, `DONE` pulses next cycle.
